// File: rtl/fp32_to_int32_iter.sv
// rtl/fp32_to_int32_iter.sv - iterative FP32 to signed int32 converter, round-to-nearest-even
module fp32_to_int32_iter #(
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t      state_q, state_d;
    logic        sign_q;
    logic        bypass_q;
    logic [31:0] byp_data_q;
    logic [2:0]  byp_flags_q;
    logic [25:0] work_q;
    logic [4:0]  rem_q;
    logic [31:0] out_data_q;
    logic [2:0]  out_flags_q;

    logic [7:0]  exp_w;
    logic [22:0] frac_w;
    logic [23:0] mant_w;
    logic [7:0]  rdist_w;
    logic [4:0]  n_w;
    logic [2:0]  lsh_amt_w;
    logic        byp_w;
    logic [31:0] lsh_mag_w;
    logic [31:0] byp_data_w;
    logic [2:0]  byp_flags_w;
    logic [25:0] shifted_w;
    logic [4:0]  rem_next_w;
    logic        round_up_w;
    logic [31:0] mag_w;
    logic [31:0] round_data_w;
    logic [2:0]  round_flags_w;

    assign exp_w     = in_data[30:23];
    assign frac_w    = in_data[22:0];
    assign mant_w    = {exp_w != 8'd0, frac_w};
    assign rdist_w   = 8'd150 - exp_w;
    assign n_w       = (rdist_w > 8'd26) ? 5'd26 : rdist_w[4:0];
    // 150 = 6 mod 8, so the low bits of E-150 only need E[2:0]
    assign lsh_amt_w = exp_w[2:0] - 3'd6;
    assign byp_w     = exp_w >= 8'd150;
    assign lsh_mag_w = {8'd0, mant_w} << lsh_amt_w;

    always_comb begin
        byp_data_w  = '0;
        byp_flags_w = '0;
        if (exp_w == 8'hFF) begin
            byp_flags_w = 3'b100;
            byp_data_w  = ((frac_w != 23'd0) || in_data[31]) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (in_data == 32'hCF00_0000) begin
            byp_data_w  = 32'h8000_0000;
        end else if (exp_w >= 8'd158) begin
            byp_flags_w = 3'b010;
            byp_data_w  = in_data[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            byp_data_w  = in_data[31] ? (~lsh_mag_w + 32'd1) : lsh_mag_w;
        end
    end

    // Working register is {mag[23:0], guard, sticky}; each step folds guard into sticky
    always_comb begin
        shifted_w  = work_q;
        rem_next_w = rem_q;
        for (int i = 0; i < SHIFT_PER_CYCLE; i++) begin
            if (rem_next_w != 5'd0) begin
                shifted_w  = {1'b0, shifted_w[25:2], shifted_w[1] | shifted_w[0]};
                rem_next_w = rem_next_w - 5'd1;
            end
        end
    end

    assign round_up_w = work_q[1] & (work_q[0] | work_q[2]);
    assign mag_w      = {8'd0, work_q[25:2]} + {31'd0, round_up_w};

    always_comb begin
        round_data_w  = bypass_q ? byp_data_q : (sign_q ? (~mag_w + 32'd1) : mag_w);
        round_flags_w = bypass_q ? byp_flags_q : {2'b00, work_q[1] | work_q[0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            bypass_q    <= 1'b0;
            byp_data_q  <= '0;
            byp_flags_q <= '0;
            work_q      <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                sign_q      <= in_data[31];
                bypass_q    <= byp_w;
                byp_data_q  <= byp_data_w;
                byp_flags_q <= byp_flags_w;
                work_q      <= {mant_w, 2'b00};
                rem_q       <= byp_w ? 5'd0 : n_w;
            end else if (state_q == SHIFT) begin
                work_q <= shifted_w;
                rem_q  <= rem_next_w;
            end
            if (state_q == ROUND) begin
                out_data_q  <= round_data_w;
                out_flags_q <= round_flags_w;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = byp_w ? ROUND : SHIFT;
            SHIFT:   if (rem_next_w == 5'd0) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) & ~rst;
        out_valid = (state_q == DONE);
        out_data  = out_data_q;
        out_flags = out_flags_q;
    end

endmodule

// File: tb/tb_fp32_to_int32_iter.sv
// tb/tb_fp32_to_int32_iter.sv - scoreboard bench for fp32_to_int32_iter
module tb_fp32_to_int32_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv1, ir1, ov1, ordy1;
    logic [31:0] id1, od1;
    logic [2:0]  of1;
    logic        iv4, ir4, ov4, ordy4;
    logic [31:0] id4, od4;
    logic [2:0]  of4;

    fp32_to_int32_iter #(.SHIFT_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_flags(of1));

    fp32_to_int32_iter #(.SHIFT_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_flags(of4));

    typedef struct {
        logic [31:0] data;
        logic [2:0]  flags;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic int lat_of(input logic [31:0] d, input int s);
        int e, n;
        e = int'(d[30:23]);
        if (e >= 150) return 1;
        n = 150 - e;
        if (n > 26) n = 26;
        return (n + s - 1) / s + 1;
    endfunction

    task automatic run1(input logic [31:0] din, input logic [31:0] ed, input logic [2:0] ef, input string name);
        exp_t e, g;
        int   lat;
        @(negedge clk);
        total++;
        if (ir1 !== 1'b1) begin bad++; $display("FAIL %s in_ready act=%b req=1", name, ir1); end
        iv1 = 1'b1; id1 = din;
        e.data = ed; e.flags = ef; e.lat = lat_of(din, 1);
        sb.push_back(e);
        @(posedge clk); #1;
        iv1 = 1'b0; id1 = $urandom;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (ov1 !== 1'b1 && lat < 200);
        total++;
        if (ov1 !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL %s no_output act=%b req=1", name, ov1);
            sb.delete();
        end else begin
            g = sb.pop_front();
            total++;
            if (od1 !== g.data) begin bad++; $display("FAIL %s data act=%h req=%h", name, od1, g.data); end
            total++;
            if (of1 !== g.flags) begin bad++; $display("FAIL %s flags act=%b req=%b", name, of1, g.flags); end
            total++;
            if (lat != g.lat) begin bad++; $display("FAIL %s latency act=%0d req=%0d", name, lat, g.lat); end
        end
        @(posedge clk); #1;
        total++;
        if (ov1 !== 1'b0) begin bad++; $display("FAIL %s handoff out_valid act=%b req=0", name, ov1); end
    endtask

    task automatic test_reset();
        rst = 1'b1; iv1 = 1'b0; id1 = '0; ordy1 = 1'b1; iv4 = 1'b0; id4 = '0; ordy4 = 1'b1;
        #12;
        total++;
        if (ov1 !== 1'b0 || od1 !== 32'h0 || of1 !== 3'b000) begin
            bad++; $display("FAIL reset_outputs act=%b/%h/%b req=0/00000000/000", ov1, od1, of1);
        end
        total++;
        if (ir1 !== 1'b0) begin bad++; $display("FAIL reset_in_ready act=%b req=0", ir1); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ir1 !== 1'b1) begin bad++; $display("FAIL release_in_ready act=%b req=1", ir1); end
    endtask

    task automatic test_rounding();
        run1(32'h3FC0_0000, 32'h0000_0002, 3'b001, "tie_1p5");
        run1(32'h4020_0000, 32'h0000_0002, 3'b001, "tie_2p5");
        run1(32'hC060_0000, 32'hFFFF_FFFC, 3'b001, "tie_m3p5");
    endtask

    task automatic test_exact();
        run1(32'h4B7F_FFFF, 32'h00FF_FFFF, 3'b000, "exact_e150");
        run1(32'h4E80_0000, 32'h4000_0000, 3'b000, "lsh_2p30");
        run1(32'h4120_0000, 32'h0000_000A, 3'b000, "ten");
        run1(32'hC120_0000, 32'hFFFF_FFF6, 3'b000, "neg_ten");
    endtask

    task automatic test_specials();
        run1(32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, "ovf_pos");
        run1(32'hCF00_0000, 32'h8000_0000, 3'b000, "min_int");
        run1(32'hCF00_0001, 32'h8000_0000, 3'b010, "ovf_neg");
        run1(32'hFF80_0000, 32'h8000_0000, 3'b100, "neg_inf");
        run1(32'h7F80_0000, 32'h7FFF_FFFF, 3'b100, "pos_inf");
        run1(32'h7FC0_0000, 32'h8000_0000, 3'b100, "nan");
    endtask

    task automatic test_underflow();
        run1(32'h3E80_0000, 32'h0000_0000, 3'b001, "quarter");
        run1(32'h0000_0001, 32'h0000_0000, 3'b001, "denormal");
        run1(32'h8000_0000, 32'h0000_0000, 3'b000, "neg_zero");
        run1(32'hBF40_0000, 32'hFFFF_FFFF, 3'b001, "neg_0p75");
    endtask

    task automatic test_handshake();
        exp_t e, g;
        int   lat;
        ordy4 = 1'b0;
        @(negedge clk);
        iv4 = 1'b1; id4 = 32'h3FC0_0000;
        e.data = 32'h0000_0002; e.flags = 3'b001; e.lat = lat_of(32'h3FC0_0000, 4);
        sb.push_back(e);
        @(posedge clk); #1;
        iv4 = 1'b0; id4 = 32'hFFFF_FFFF;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (ov4 !== 1'b1 && lat < 200);
        total++;
        if (ov4 !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL hs_no_output act=%b req=1", ov4);
            sb.delete();
        end else begin
            g = sb.pop_front();
            total++;
            if (od4 !== g.data || of4 !== g.flags) begin
                bad++; $display("FAIL hs_result act=%h/%b req=%h/%b", od4, of4, g.data, g.flags);
            end
            total++;
            if (lat != g.lat) begin bad++; $display("FAIL hs_latency act=%0d req=%0d", lat, g.lat); end
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (ov4 !== 1'b1 || od4 !== 32'h2 || of4 !== 3'b001 || ir4 !== 1'b0) begin
                bad++; $display("FAIL hs_hold%0d act=%b/%h/%b/%b req=1/00000002/001/0", i, ov4, od4, of4, ir4);
            end
        end
        @(negedge clk); ordy4 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
            bad++; $display("FAIL hs_release act=%b/%b req=0/1", ov4, ir4);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        bit   seen;
        @(negedge clk);
        iv1 = 1'b1; id1 = 32'h3F80_0000;
        e.data = 32'h1; e.flags = 3'b000; e.lat = lat_of(32'h3F80_0000, 1);
        sb.push_back(e);
        @(posedge clk); #1;
        iv1 = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (ov1 !== 1'b0 || ir1 !== 1'b0) begin
                bad++; $display("FAIL abort_in_reset%0d act=%b/%b req=0/0", i, ov1, ir1);
            end
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ir1 !== 1'b1) begin bad++; $display("FAIL abort_release_in_ready act=%b req=1", ir1); end
        for (int i = 0; i < 30; i++) begin
            if (ov1 === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL abort_ghost_output act=1 req=0"); end
        run1(32'h4000_0000, 32'h0000_0002, 3'b000, "after_abort");
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_exact();
        test_specials();
        test_underflow();
        test_handshake();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
